data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Multi-cycle data-memory responder serving the pipeline's Memory-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It replaces the single-cycle data memory. It drives a stall request toward the hazard unit while an access is outstanding, so the pipeline holds its Memory stage. Accesses are word-only, with fixed, parameterised read and write latencies.

Parameters:
DATA_WIDTH, 32, width of a data word.
ADDR_WIDTH, 32, width of the byte address.
DEPTH_WORDS, 1024, number of words stored; power of two.
READ_LATENCY, 2, cycles from request acceptance to read response; minimum 1.
WRITE_LATENCY, 1, cycles from request acceptance to write acknowledge; minimum 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  Memory stage presents a request.
req_write  input  1  1 = store, 0 = load.
req_address  input  ADDR_WIDTH  byte address (the ALU result in the Memory stage).
req_write_data  input  DATA_WIDTH  store data.
req_ready  output  1  responder can accept a request this cycle.
resp_valid  output  1  one-cycle pulse; the response is complete.
resp_read_data  output  DATA_WIDTH  load data; valid only while resp_valid=1.
resp_error  output  1  misaligned access; valid only while resp_valid=1.
mem_stall  output  1  stall request to the hazard unit.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, latched request cleared, all storage words zeroed. Outputs: req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0, mem_stall=0.
- States and transitions:
  - IDLE: on acceptance, go to WAIT if the selected latency is >1, else to RESPOND.
  - WAIT: go to RESPOND when the counter reaches 1.
  - RESPOND: return to IDLE unconditionally.
- Handshake:
  - A request is accepted when req_valid & req_ready; req_ready=1 only in IDLE.
  - On acceptance, latch address, write flag and write data.
  - Input changes after acceptance are ignored.
- Latency counter: loaded with the selected latency on acceptance and decremented in WAIT.
- Response timing:
  - If acceptance occurs in cycle T, resp_valid=1 in exactly cycle T+LATENCY (READ_ or WRITE_ per the latched flag).
  - resp_valid is 0 in every other cycle.
- Stall rule: mem_stall = (IDLE & req_valid) | WAIT. mem_stall is 0 in RESPOND, so the pipeline advances on the response edge.
- Re-acceptance: the held request is still on the inputs in RESPOND but is not re-accepted (req_ready=0). The next request can be accepted in the following IDLE cycle.
- Throughput: at most one access per LATENCY+1 cycles.
- Word index = req_address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Store: the word is written on the RESPOND-cycle edge. resp_read_data=0 during a store response.
- Load: resp_read_data holds the word at the latched index, sampled in RESPOND.
- Misaligned access (latched address[1:0] != 0):
  - Still takes the full latency.
  - resp_error=1, no storage write, resp_read_data=0.
- Outputs are held at 0 whenever resp_valid=0.
- Reset asserted mid-access: the pending access is abandoned, a store is not committed, and no response is produced. The next cycle is IDLE.
- req_valid dropping while in WAIT: the access still completes, and its response is still produced.

Decomposition:
- Shared package: state encoding constants (IDLE, WAIT, RESPOND), latency counter width, and the index-width function (clog2 of DEPTH_WORDS).
- Sub-module memory_word_array: DEPTH_WORDS x DATA_WIDTH storage with synchronous write, combinational read and synchronous reset-to-zero.
- The responder FSM, counter and request latches stay in data_memory_responder.

Test Plan:
- Reset then idle: req_valid=0 -> req_ready=1, mem_stall=0, resp_valid=0. Load from address 0x10 returns 0x00000000.
- Store then load: store 0xDEADBEEF to 0x20 accepted at T0 -> resp_valid at T0+1, mem_stall=1 only in cycle T0. Load 0x20 accepted next IDLE cycle T1 -> resp_read_data=0xDEADBEEF at T1+2.
- Back-to-back loads with req_valid held high: exactly one acceptance per 3 cycles, no duplicate responses. mem_stall pattern 1,1,0 repeating.
- Misaligned store to 0x22 with data 0x12345678 -> resp_error=1 at T+1. A subsequent load of 0x20 returns its prior value, unchanged.
- Wrap-around: store 0xA5A5A5A5 to 0x1000 (DEPTH 1024) -> load from 0x0 returns 0xA5A5A5A5.
- Reset mid-store: store 0x55 to 0x40 with WRITE_LATENCY=3, reset asserted at T+1 -> no resp_valid; state IDLE next cycle; load 0x40 returns 0.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package data_memory_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   // Wide enough for any latency this block is realistically configured with.
   localparam int CNT_WIDTH = 8;

   function automatic int index_width(input int depth_words);
      return (depth_words > 1) ? $clog2(depth_words) : 1;
   endfunction

endpackage

// File: rtl/data_memory_responder_memory_word_array.sv
// Word storage: synchronous write, combinational read, synchronous clear-to-zero.
module memory_word_array #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_WIDTH   = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [IDX_WIDTH-1:0]  wr_index,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_WIDTH-1:0]  rd_index,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_index] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_index];

endmodule

// File: rtl/data_memory_responder.sv
// Memory-stage load/store responder with fixed read/write latency and a stall
// request held toward the hazard unit while an access is outstanding.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | ready; accepts req_valid, stalls pipe while it is presented
// ST_WAIT    | access in flight, counter counting down to 1
// ST_RESPOND | one-cycle response; store commits on this cycle's edge
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int DEPTH_WORDS   = 1024,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_write_data,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_read_data,
   output logic                  resp_error,
   output logic                  mem_stall
);

   localparam int IDX_WIDTH = index_width(DEPTH_WORDS);

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic                   write_q, write_d;
   logic                   misalign_q, misalign_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [CNT_WIDTH-1:0]   lat_sel;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  rd_data;

   // Upper address bits are deliberately ignored so addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_address[ADDR_WIDTH-1:IDX_WIDTH+2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      write_d    = write_q;
      misalign_d = misalign_q;
      wdata_d    = wdata_q;
      lat_sel    = req_write ? CNT_WIDTH'(WRITE_LATENCY) : CNT_WIDTH'(READ_LATENCY);
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               idx_d      = req_address[IDX_WIDTH+1:2];
               misalign_d = (req_address[1:0] != 2'b00);
               write_d    = req_write;
               wdata_d    = req_write_data;
               cnt_d      = lat_sel;
               state_d    = (lat_sel > CNT_WIDTH'(1)) ? ST_WAIT : ST_RESPOND;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
            if (cnt_d == CNT_WIDTH'(1)) begin
               state_d = ST_RESPOND;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         write_q    <= 1'b0;
         misalign_q <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         write_q    <= write_d;
         misalign_q <= misalign_d;
         wdata_q    <= wdata_d;
      end
   end

   assign req_ready      = (state_q == ST_IDLE);
   assign resp_valid     = (state_q == ST_RESPOND);
   assign mem_stall      = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
   assign resp_error     = resp_valid && misalign_q;
   assign resp_read_data = (resp_valid && !write_q && !misalign_q) ? rd_data : '0;
   assign wr_en          = resp_valid && write_q && !misalign_q;

   memory_word_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_mem (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_index (idx_q),
      .wr_data  (wdata_q),
      .rd_index (idx_q),
      .rd_data  (rd_data)
   );

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against a word-array model.
module tb_data_memory_responder;

   localparam int RL    = 2;
   localparam int WL    = 1;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst, rst_w3;
   logic        req_valid, req_write;
   logic [31:0] req_address, req_write_data;
   logic        req_ready, resp_valid, resp_error, mem_stall;
   logic [31:0] resp_read_data;

   logic        w3_valid, w3_write;
   logic [31:0] w3_address, w3_write_data;
   logic        w3_ready, w3_resp_valid, w3_resp_error, w3_stall;
   logic [31:0] w3_read_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   data_memory_responder #(.READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
      .clk(clk), .reset(rst), .req_valid(req_valid), .req_write(req_write),
      .req_address(req_address), .req_write_data(req_write_data),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_read_data(resp_read_data),
      .resp_error(resp_error), .mem_stall(mem_stall)
   );

   data_memory_responder #(.READ_LATENCY(2), .WRITE_LATENCY(3)) dut_w3 (
      .clk(clk), .reset(rst_w3), .req_valid(w3_valid), .req_write(w3_write),
      .req_address(w3_address), .req_write_data(w3_write_data),
      .req_ready(w3_ready), .resp_valid(w3_resp_valid), .resp_read_data(w3_read_data),
      .resp_error(w3_resp_error), .mem_stall(w3_stall)
   );

   // Drives one access on the main instance and reports what was observed.
   task automatic drive_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                               output int lat, output logic [31:0] rdata, output logic err,
                               output int stall_cnt, output logic stall_resp, output int dirty);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_address = addr; req_write_data = wd;
      #1;
      stall_cnt = mem_stall ? 1 : 0;
      dirty = req_ready ? 0 : 1;
      lat = 0; rdata = 'x; err = 1'bx; stall_resp = 1'bx;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_write = ~wr; req_address = $urandom; req_write_data = $urandom;
         end
         #1;
         if (resp_valid) begin
            lat = k; rdata = resp_read_data; err = resp_error; stall_resp = mem_stall;
            break;
         end
         if (resp_read_data !== 32'h0 || resp_error !== 1'b0) dirty++;
         if (mem_stall) stall_cnt++;
      end
      req_valid = 1'b0;
   endtask

   function automatic int midx(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   task automatic test_reset;
      int lat, sc, dirty; logic [31:0] rd; logic er, sr;
      rst = 1'b1; rst_w3 = 1'b1;
      req_valid = 0; req_write = 0; req_address = 0; req_write_data = 0;
      w3_valid = 0; w3_write = 0; w3_address = 0; w3_write_data = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0; rst_w3 = 1'b0;
      #1;
      checks++;
      if ({req_ready, mem_stall, resp_valid, resp_error} !== 4'b1000 || resp_read_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ready=%b stall=%b valid=%b err=%b data=%h, want 1 0 0 0 0",
                  req_ready, mem_stall, resp_valid, resp_error, resp_read_data);
      end
      drive_access(1'b0, 32'h10, 32'h0, lat, rd, er, sc, sr, dirty);
      checks++;
      if (lat !== RL || rd !== 32'h0 || er !== 1'b0) begin
         errors++;
         $display("FAIL reset_load: got lat=%0d data=%h err=%b, want lat=%0d data=0 err=0", lat, rd, er, RL);
      end
   endtask

   task automatic test_store_load;
      int lat, sc, dirty; logic [31:0] rd; logic er, sr;
      drive_access(1'b1, 32'h20, 32'hDEADBEEF, lat, rd, er, sc, sr, dirty);
      model_mem[midx(32'h20)] = 32'hDEADBEEF;
      checks++;
      if (lat !== WL || rd !== 32'h0 || er !== 1'b0) begin
         errors++;
         $display("FAIL store_resp: got lat=%0d data=%h err=%b, want lat=%0d data=0 err=0", lat, rd, er, WL);
      end
      checks++;
      if (sc !== WL || sr !== 1'b0 || dirty !== 0) begin
         errors++;
         $display("FAIL store_stall: got stall_cycles=%0d stall_at_resp=%b dirty=%0d, want %0d 0 0", sc, sr, dirty, WL);
      end
      drive_access(1'b0, 32'h20, 32'h0, lat, rd, er, sc, sr, dirty);
      checks++;
      if (lat !== RL || rd !== 32'hDEADBEEF || er !== 1'b0 || sc !== RL || sr !== 1'b0 || dirty !== 0) begin
         errors++;
         $display("FAIL load_after_store: got lat=%0d data=%h err=%b stall=%0d/%b dirty=%0d, want %0d deadbeef 0 %0d/0 0",
                  lat, rd, er, sc, sr, dirty, RL, RL);
      end
   endtask

   task automatic test_back_to_back;
      int accepts = 0, resps = 0;
      logic [2:0] exp_bits, got_bits;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_address = 32'h20; req_write_data = 32'h0;
      for (int c = 0; c < 4 * (RL + 1); c++) begin
         #1;
         exp_bits = {((c % (RL + 1)) == 0), ((c % (RL + 1)) != RL), ((c % (RL + 1)) == RL)};
         got_bits = {req_ready, mem_stall, resp_valid};
         if (req_ready) accepts++;
         if (resp_valid) begin
            resps++;
            checks++;
            if (resp_read_data !== model_mem[midx(32'h20)]) begin
               errors++;
               $display("FAIL b2b_data cycle %0d: got %h want %h", c, resp_read_data, model_mem[midx(32'h20)]);
            end
         end
         checks++;
         if (got_bits !== exp_bits) begin
            errors++;
            $display("FAIL b2b_pattern cycle %0d: got ready/stall/valid=%b want %b", c, got_bits, exp_bits);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (accepts !== 4 || resps !== 4) begin
         errors++;
         $display("FAIL b2b_counts: got accepts=%0d resps=%0d want 4 4", accepts, resps);
      end
   endtask

   task automatic test_misaligned;
      int lat, sc, dirty; logic [31:0] rd; logic er, sr;
      drive_access(1'b1, 32'h22, 32'h12345678, lat, rd, er, sc, sr, dirty);
      checks++;
      if (lat !== WL || er !== 1'b1 || rd !== 32'h0) begin
         errors++;
         $display("FAIL misaligned_store: got lat=%0d err=%b data=%h, want %0d 1 0", lat, er, rd, WL);
      end
      drive_access(1'b0, 32'h20, 32'h0, lat, rd, er, sc, sr, dirty);
      checks++;
      if (lat !== RL || er !== 1'b0 || rd !== model_mem[midx(32'h20)]) begin
         errors++;
         $display("FAIL misaligned_no_write: got lat=%0d err=%b data=%h, want %0d 0 %h",
                  lat, er, rd, RL, model_mem[midx(32'h20)]);
      end
   endtask

   task automatic test_wrap;
      int lat, sc, dirty; logic [31:0] rd; logic er, sr;
      drive_access(1'b1, 32'h1000, 32'hA5A5A5A5, lat, rd, er, sc, sr, dirty);
      model_mem[midx(32'h1000)] = 32'hA5A5A5A5;
      drive_access(1'b0, 32'h0, 32'h0, lat, rd, er, sc, sr, dirty);
      checks++;
      if (lat !== RL || rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
         errors++;
         $display("FAIL wrap_load: got lat=%0d data=%h err=%b, want %0d a5a5a5a5 0", lat, rd, er, RL);
      end
   endtask

   task automatic test_random;
      int lat, sc, dirty, exp_lat; logic [31:0] rd, addr, wd, exp_rd; logic er, sr, wr, exp_er;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         addr = $urandom;
         addr[11:2] = 10'($urandom_range(0, 15));
         addr[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         wd = $urandom;
         exp_er  = (addr[1:0] != 2'b00);
         exp_lat = wr ? WL : RL;
         exp_rd  = (!wr && !exp_er) ? model_mem[midx(addr)] : 32'h0;
         drive_access(wr, addr, wd, lat, rd, er, sc, sr, dirty);
         if (wr && !exp_er) model_mem[midx(addr)] = wd;
         checks++;
         if (lat !== exp_lat || rd !== exp_rd || er !== exp_er || sc !== exp_lat || sr !== 1'b0 || dirty !== 0) begin
            errors++;
            $display("FAIL random[%0d] wr=%b addr=%h: got lat=%0d data=%h err=%b stall=%0d/%b dirty=%0d, want %0d %h %b %0d/0 0",
                     n, wr, addr, lat, rd, er, sc, sr, dirty, exp_lat, exp_rd, exp_er, exp_lat);
         end
      end
   endtask

   task automatic test_reset_mid_store;
      int spurious = 0, lat = 0; logic [31:0] rd = 'x;
      @(negedge clk);
      w3_valid = 1'b1; w3_write = 1'b1; w3_address = 32'h40; w3_write_data = 32'h55;
      @(posedge clk);
      @(negedge clk);
      rst_w3 = 1'b1; w3_valid = 1'b0;
      @(negedge clk);
      rst_w3 = 1'b0;
      #1;
      checks++;
      if (w3_ready !== 1'b1 || w3_resp_valid !== 1'b0 || w3_stall !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle: got ready=%b valid=%b stall=%b want 1 0 0", w3_ready, w3_resp_valid, w3_stall);
      end
      repeat (5) begin
         @(negedge clk); #1;
         if (w3_resp_valid !== 1'b0) spurious++;
      end
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("FAIL midreset_no_resp: got %0d responses want 0", spurious);
      end
      @(negedge clk);
      w3_valid = 1'b1; w3_write = 1'b0; w3_address = 32'h40;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk); #1;
         if (w3_resp_valid) begin lat = k; rd = w3_read_data; break; end
      end
      w3_valid = 1'b0;
      checks++;
      if (lat !== 2 || rd !== 32'h0) begin
         errors++;
         $display("FAIL midreset_load: got lat=%0d data=%h want 2 00000000", lat, rd);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_misaligned();
      test_wrap();
      test_random();
      test_reset_mid_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
